// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants and state type for the nibble-serial add/subtract controller.
package serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_nibble_add4.sv
// Combinational 4-bit ripple-carry slice; c3 exposes the carry into bit 3
// so the caller can derive signed overflow on the most significant nibble.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract computed one nibble per clock through a single shared
// 4-bit slice, with valid/ready handshakes on operand and result sides.
//
//   state | meaning
//   IDLE  | ready for a new operation (in_ready=1)
//   RUN   | one slice pass per cycle, LSB nibble first, NIBBLES cycles
//   DONE  | result presented (out_valid=1), held until out_ready
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_sh_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0] slice_s;
    logic       slice_co;
    logic       slice_c3;

    nibble_add4 u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // Each slice result enters from the top so that after NIBBLES passes the
    // first (least significant) nibble has reached bit 0.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_sh_d = slice_s;
        end else begin : g_multi
            assign sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= a;
                        b_sh_q     <= sub ? ~b : b;
                        carry_q    <= sub ? 1'b1 : cin;
                        cnt_q      <= '0;
                        sum_sh_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> NIBBLE_W;
                    b_sh_q   <= b_sh_q >> NIBBLE_W;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= slice_co;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q       <= sum_sh_d;
                        cout_q      <= slice_co;
                        ovf_q       <= slice_c3 ^ slice_co;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: stimulus pushes arithmetic expectations, a negedge monitor
// pops and compares whenever a result is handed over.
module tb_serial_add_ctrl;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   bp_rand = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the whole words.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb, input int acc);
        exp_t   e;
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint sa = longint'($signed(av));
        longint sbv = longint'($signed(bv));
        longint r;
        longint u;
        if (sb) begin
            r    = sa - sbv;
            u    = (ua - ub) & 64'hFFFF;
            e.co = (ua >= ub);
        end else begin
            r    = sa + sbv + longint'(ci);
            u    = ua + ub + longint'(ci);
            e.co = (u >= 65536);
        end
        e.s   = u[W-1:0];
        e.ov  = (r > 32767) || (r < -32768);
        e.acc = acc;
        return e;
    endfunction

    // Monitor
    bit           seen = 0;
    logic [W-1:0] hold_s;
    logic         hold_c;
    logic         hold_o;
    exp_t         e;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen   = 1;
                hold_s = sum;
                hold_c = cout;
                hold_o = ovf;
                if (q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency", cyc - q[0].acc, NIBBLES);
            end else begin
                chk("hold_stable", {hold_s, hold_c, hold_o}, {sum, cout, ovf});
            end
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.co);
                chk("ovf", ovf, e.ov);
                seen = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb);
        int n = 0;
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1, 0);
        end else begin
            q.push_back(model(av, bv, ci, sb, cyc + 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {sum, cout, ovf}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0); drain();
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0); drain();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1); drain();
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();

        // Backpressure: result held, new request ignored until handshake
        out_ready = 1'b0;
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        for (int n = 0; n < 50 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", out_valid, 1);
        a = 16'hA5A5; b = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        q.push_back(model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, cyc + 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", in_ready, 0);
        drain();

        // Reset after two RUN cycles discards the operation
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0); drain();

        // Random operations with random result backpressure
        bp_rand = 1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) ra = 16'h7FFF;
            if (i % 8 == 1) rb = 16'h8000;
            if (i % 8 == 2) ra = 16'hFFFF;
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        bp_rand = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
